exec_wb_unit: RTL and testbench

Multi-cycle execute/write-back stage sitting directly in front of the 8×8 register file (r0 hardwired to zero, one write port, two combinational read ports). It accepts one decoded instruction at a time (op, rd, rs, rt) and drives the file's read addresses. It captures the two operands, computes an 8-bit result (single-cycle ALU ops or an 8-cycle shift-add multiply) and writes the result back through the file's write port. It is serial: one instruction in flight, so there are no read-after-write hazards.

---
 rtl/exec_wb_unit.sv | 206 ++++++++++++++++++++
 tb/tb_exec_wb_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_wb_unit.sv
// Serial execute/write-back stage in front of an 8x8 register file.
// Optional 8-cycle shift-add multiplier for op 7 enabled by EXEC_MUL_EN.
module exec_wb_unit (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  output logic       ready,
  input  logic [2:0] op,
  input  logic [2:0] rd,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  output logic [2:0] RX,
  output logic [2:0] RY,
  input  logic [7:0] busX,
  input  logic [7:0] busY,
  output logic       WEN,
  output logic [2:0] RW,
  output logic [7:0] busW,
  output logic       done,
  output logic       ill_op
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DW-1:0] alu_c;
  logic          ill_c;

  logic          ready_q, ready_d, wen_q, wen_d, done_q, done_d, ill_q, ill_d;
  logic [AW-1:0] rx_q, rx_d, ry_q, ry_d, rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d;

`ifdef EXEC_MUL_EN
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          fin_q, fin_d;
  assign ill_c = 1'b0;
`else
  assign ill_c = (op_q == 3'd7);
`endif

  // Single-cycle ALU on the captured operands
  always_comb begin
    alu_c = '0;
    case (op_q)
      3'd0:    alu_c = a_q + b_q;
      3'd1:    alu_c = a_q - b_q;
      3'd2:    alu_c = a_q & b_q;
      3'd3:    alu_c = a_q | b_q;
      3'd4:    alu_c = a_q ^ b_q;
      3'd5:    alu_c = ($signed(a_q) < $signed(b_q)) ? 8'd1 : 8'd0;
      3'd6:    alu_c = a_q << b_q[2:0];
      default: alu_c = '0;
    endcase
  end

  // Next-state logic; outputs are precomputed from the next state so they register cleanly
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef EXEC_MUL_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    fin_d   = fin_q;
`endif
    ready_d = 1'b0;
    rx_d    = '0;
    ry_d    = '0;
    wen_d   = 1'b0;
    rw_d    = '0;
    busw_d  = '0;
    done_d  = 1'b0;
    ill_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd;
          rs_d    = rs;
          rt_d    = rt;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = busX;
        b_d     = busY;
`ifdef EXEC_MUL_EN
        cnt_d   = '0;
        acc_d   = '0;
        fin_d   = 1'b0;
`endif
        state_d = S_EXEC;
      end
      S_EXEC: begin
`ifdef EXEC_MUL_EN
        if (op_q == 3'd7) begin
          // Eight accumulate cycles, then one cycle to hand the product to res_q
          if (fin_q) begin
            res_d   = acc_q;
            state_d = S_WB;
          end else begin
            if (b_q[cnt_q]) acc_d = acc_q + (a_q << cnt_q);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) fin_d = 1'b1;
          end
        end else begin
          res_d   = alu_c;
          state_d = S_WB;
        end
`else
        res_d   = alu_c;
        state_d = S_WB;
`endif
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_READ: begin
        rx_d = rs_d;
        ry_d = rt_d;
      end
      S_WB: begin
        done_d = 1'b1;
        ill_d  = ill_c;
        rw_d   = rd_q;
        busw_d = res_d;
        wen_d  = (rd_q != '0) && !ill_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef EXEC_MUL_EN
      cnt_q   <= '0;
      acc_q   <= '0;
      fin_q   <= 1'b0;
`endif
      ready_q <= 1'b1;
      rx_q    <= '0;
      ry_q    <= '0;
      wen_q   <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef EXEC_MUL_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      fin_q   <= fin_d;
`endif
      ready_q <= ready_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      wen_q   <= wen_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign ready  = ready_q;
  assign RX     = rx_q;
  assign RY     = ry_q;
  assign WEN    = wen_q;
  assign RW     = rw_q;
  assign busW   = busw_q;
  assign done   = done_q;
  assign ill_op = ill_q;

endmodule

// File: tb/tb_exec_wb_unit.sv
// Scoreboard bench for exec_wb_unit with a behavioural register-file model.
// Honours EXEC_MUL_EN the same way as the design.
module tb_exec_wb_unit;

  logic       Clk = 1'b0;
  logic       Rst, start;
  logic [2:0] op, rd, rs, rt;
  logic [7:0] busX, busY;
  logic       ready, WEN, done, ill_op;
  logic [2:0] RX, RY, RW;
  logic [7:0] busW;

  exec_wb_unit dut (
    .Clk(Clk), .Rst(Rst), .start(start), .ready(ready),
    .op(op), .rd(rd), .rs(rs), .rt(rt),
    .RX(RX), .RY(RY), .busX(busX), .busY(busY),
    .WEN(WEN), .RW(RW), .busW(busW), .done(done), .ill_op(ill_op)
  );

  always #5 Clk = ~Clk;

  // Register file seen by the DUT, with a preload port for the bench
  logic [7:0] rf [8];
  logic       pl_en = 1'b0;
  logic [2:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  assign busX = (RX == 3'd0) ? 8'd0 : rf[RX];
  assign busY = (RY == 3'd0) ? 8'd0 : rf[RY];
  always @(posedge Clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (WEN && RW != 3'd0) rf[RW] <= busW;
  end

  typedef struct {
    logic       wen;
    logic [2:0] rw;
    logic [7:0] data;
    logic       ill;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   mdl [8];
  int   cyc = 0;
  int   vecs = 0;
  int   miscompares = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst) begin
      if (WEN) check("wen_implies_done", int'(done), 1);
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("wb_wen", int'(WEN), int'(e.wen));
          check("wb_rw", int'(RW), int'(e.rw));
          check("wb_ill", int'(ill_op), int'(e.ill));
          check("wb_latency", cyc, e.cyc);
          if (!e.ill) check("wb_data", int'(busW), int'(e.data));
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (ready) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] v);
    wait_ready();
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge Clk);
    pl_en = 1'b0;
    if (a != 3'd0) mdl[a] = int'(v);
  endtask

  // Reference result from the instruction semantics, not the RTL structure
  task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s,
                       input logic [2:0] t, input int hold);
    int a, b, r, sa, sb, lat;
    bit il;
    exp_t e;
    wait_ready();
    op = o; rd = d; rs = s; rt = t; start = 1'b1;
    @(posedge Clk); #1;
    a = mdl[s]; b = mdl[t];
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    il = 1'b0; lat = 2; r = 0;
    case (o)
      3'd0: r = (a + b) % 256;
      3'd1: r = (a - b + 256) % 256;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = (a * (1 << (b % 8))) % 256;
      default: begin
`ifdef EXEC_MUL_EN
        r = (a * b) % 256; lat = 10;
`else
        il = 1'b1;
`endif
      end
    endcase
    e.wen = (d != 3'd0) && !il;
    e.rw = d; e.data = 8'(r); e.ill = il; e.cyc = cyc + lat;
    sbq.push_back(e);
    if (e.wen) mdl[d] = r;
    repeat (hold) @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge Clk);
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; op = '0; rd = '0; rs = '0; rt = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_ready", int'(ready), 1);
    check("rst_wen", int'(WEN), 0);
    check("rst_done", int'(done), 0);
    check("rst_rx", int'(RX), 0);
    check("rst_ry", int'(RY), 0);
    check("rst_rw", int'(RW), 0);
    check("rst_busw", int'(busW), 0);
    check("rst_ill", int'(ill_op), 0);
    Rst = 1'b0;

    for (int i = 1; i < 8; i++) preload(3'(i), 8'($urandom_range(0, 255)));

    preload(3'd1, 8'd200); preload(3'd2, 8'd100);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 0);
    issue(3'd1, 3'd4, 3'd3, 3'd1, 0);

    preload(3'd1, 8'hF0); preload(3'd2, 8'h05);
    issue(3'd5, 3'd5, 3'd1, 3'd2, 0);
    issue(3'd6, 3'd6, 3'd2, 3'd2, 2);

    preload(3'd1, 8'd13); preload(3'd2, 8'd11);
    issue(3'd7, 3'd7, 3'd1, 3'd2, 0);
    preload(3'd1, 8'd20); preload(3'd2, 8'd20);
    issue(3'd7, 3'd7, 3'd1, 3'd2, 0);

    issue(3'd0, 3'd0, 3'd1, 3'd2, 0);

    // Abort an instruction mid-flight; nothing must be written or signalled
    wait_ready();
`ifdef EXEC_MUL_EN
    op = 3'd7;
`else
    op = 3'd0;
`endif
    rd = 3'd5; rs = 3'd1; rt = 3'd2; start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
`ifdef EXEC_MUL_EN
    repeat (3) @(negedge Clk);
`endif
    Rst = 1'b1;
    @(negedge Clk);
    check("abort_ready", int'(ready), 1);
    check("abort_wen", int'(WEN), 0);
    check("abort_done", int'(done), 0);
    Rst = 1'b0;
    repeat (12) @(negedge Clk);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0)
        preload(3'($urandom_range(1, 7)), 8'($urandom_range(0, 255)));
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 2)));
    end

    drain();
    repeat (3) @(negedge Clk);
    for (int i = 1; i < 8; i++) check($sformatf("final_r%0d", i), int'(rf[i]), mdl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
